// File: rtl/oserdes_pkg.sv
// Shared constants, types and helpers for the ddr_oserdes serializer family.
// The lane-slice macro gives the LSB of lane n inside a packed LANES*RATIO word.
`ifndef OSERDES_PKG_SV
`define OSERDES_PKG_SV
`define OSERDES_LANE_LSB(n, r) ((n) * (r))

package oserdes_pkg;

    localparam int unsigned DEF_LANES = 2;
    localparam int unsigned DEF_RATIO = 4;

    typedef enum logic {
        SH_IDLE   = 1'b0,
        SH_ACTIVE = 1'b1
    } sh_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

`endif

// File: rtl/oserdes_lane.sv
// One serial lane: hold slice, shifter slice and the registered output bit.
// All strobes arrive pre-qualified by the shared control in ddr_oserdes.
module oserdes_lane
    import oserdes_pkg::*;
#(
    parameter int unsigned RATIO     = DEF_RATIO,
    parameter bit          MSB_FIRST = 1'b0,
    parameter logic        IDLE_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             hold_wr,
    input  logic             load_hold,
    input  logic             load_in,
    input  logic             advance,
    input  logic             go_idle,
    input  logic [RATIO-1:0] din,
    output logic             q
);

    logic [RATIO-1:0] hold_q, hold_d;
    logic [RATIO-1:0] sh_q, sh_d;
    logic             q_q, q_d;

    function automatic logic first_bit(input logic [RATIO-1:0] w);
        return MSB_FIRST ? w[RATIO-1] : w[0];
    endfunction

    // The shifter keeps only the bits still to leave, pre-aligned to the exit end.
    function automatic logic [RATIO-1:0] remaining(input logic [RATIO-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    always_comb begin
        hold_d = hold_q;
        sh_d   = sh_q;
        q_d    = q_q;
        if (hold_wr) hold_d = din;
        if (load_hold) begin
            q_d  = first_bit(hold_q);
            sh_d = remaining(hold_q);
        end else if (load_in) begin
            q_d  = first_bit(din);
            sh_d = remaining(din);
        end else if (advance) begin
            q_d  = first_bit(sh_q);
            sh_d = remaining(sh_q);
        end else if (go_idle) begin
            q_d = IDLE_VAL;
        end
        if (reset) begin
            q_d = IDLE_VAL;
        end else if (set) begin
            q_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        sh_q   <= sh_d;
        q_q    <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/ddr_oserdes.sv
// Multi-lane valid/ready output serializer with a one-word holding buffer.
// Shared control (counter, state, hold flag, handshake) lives here; data lives in the lanes.
module ddr_oserdes
    import oserdes_pkg::*;
#(
    parameter int unsigned LANES     = DEF_LANES,
    parameter int unsigned RATIO     = DEF_RATIO,
    parameter bit          MSB_FIRST = 1'b0,
    parameter logic        IDLE_VAL  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   set,
    input  logic                   in_valid,
    input  logic [LANES*RATIO-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       Q,
    output logic                   out_valid,
    output logic                   underrun
);

    localparam int unsigned    CW   = (clog2(RATIO) < 1) ? 1 : clog2(RATIO);
    localparam logic [CW-1:0]  LAST = CW'(RATIO - 1);

    sh_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hold_full_q, hold_full_d;
    logic          out_valid_q, out_valid_d;
    logic          underrun_q, underrun_d;

    logic accept, load_pt;
    logic hold_wr, load_hold, load_in, advance, go_idle;

    assign in_ready = ce & ~reset & ~set & ~hold_full_q;
    assign accept   = in_valid & in_ready;
    assign load_pt  = (state_q == SH_IDLE) | (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        out_valid_d = out_valid_q;
        underrun_d  = 1'b0;
        hold_wr     = 1'b0;
        load_hold   = 1'b0;
        load_in     = 1'b0;
        advance     = 1'b0;
        go_idle     = 1'b0;
        if (reset | set) begin
            state_d     = SH_IDLE;
            cnt_d       = '0;
            hold_full_d = 1'b0;
            out_valid_d = 1'b0;
        end else if (ce) begin
            if (load_pt) begin
                if (hold_full_q) begin
                    load_hold   = 1'b1;
                    hold_wr     = accept;
                    hold_full_d = accept;
                    state_d     = SH_ACTIVE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                end else if (accept) begin
                    load_in     = 1'b1;
                    state_d     = SH_ACTIVE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = SH_IDLE;
                    cnt_d   = '0;
                    // Only a stream that was actually running produces the end-of-stream pulse.
                    if (state_q == SH_ACTIVE) begin
                        go_idle     = 1'b1;
                        out_valid_d = 1'b0;
                        underrun_d  = 1'b1;
                    end
                end
            end else begin
                advance = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (accept) begin
                    hold_wr     = 1'b1;
                    hold_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        hold_full_q <= hold_full_d;
        out_valid_q <= out_valid_d;
        underrun_q  <= underrun_d;
    end

    assign out_valid = out_valid_q;
    assign underrun  = underrun_q;

    genvar n;
    generate
        for (n = 0; n < LANES; n++) begin : g_lane
            oserdes_lane #(
                .RATIO     (RATIO),
                .MSB_FIRST (MSB_FIRST),
                .IDLE_VAL  (IDLE_VAL)
            ) u_lane (
                .clk       (clk),
                .reset     (reset),
                .set       (set),
                .hold_wr   (hold_wr),
                .load_hold (load_hold),
                .load_in   (load_in),
                .advance   (advance),
                .go_idle   (go_idle),
                .din       (in_data[`OSERDES_LANE_LSB(n, RATIO) +: RATIO]),
                .q         (Q[n])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ddr_oserdes.sv
// Self-checking bench for ddr_oserdes: directed scenarios plus random traffic,
// checked against a bit-stream queue model of the serializer.
module tb_ddr_oserdes;

    localparam int unsigned LANES = 2;
    localparam int unsigned RATIO = 4;

    logic                   clk;
    logic                   reset;
    logic                   ce;
    logic                   set;
    logic                   in_valid;
    logic [LANES*RATIO-1:0] in_data;
    logic                   in_ready;
    logic [LANES-1:0]       Q;
    logic                   out_valid;
    logic                   underrun;

    ddr_oserdes #(
        .LANES     (LANES),
        .RATIO     (RATIO),
        .MSB_FIRST (1'b0),
        .IDLE_VAL  (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .set       (set),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .Q         (Q),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: every accepted word appends its RATIO output vectors to a stream;
    // each enabled edge shows the next vector, or ends the stream when empty.
    logic [LANES-1:0] stream[$];
    logic [LANES-1:0] exp_q  = '0;
    logic             exp_ov = 1'b0;
    logic             exp_ur = 1'b0;
    logic             last_acc = 1'b0;
    int               ov_cnt = 0;
    int               ur_cnt = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic             exp_rdy;
        logic [LANES-1:0] v;
        @(negedge clk);
        exp_rdy = ce && !reset && !set && (stream.size() < RATIO);
        chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
        last_acc = in_valid && exp_rdy;
        @(posedge clk);
        if (reset) begin
            stream.delete();
            exp_q = '0; exp_ov = 1'b0; exp_ur = 1'b0;
        end else if (set) begin
            stream.delete();
            exp_q = '1; exp_ov = 1'b0; exp_ur = 1'b0;
        end else if (!ce) begin
            exp_ur = 1'b0;
        end else begin
            if (last_acc) begin
                for (int k = 0; k < RATIO; k++) begin
                    for (int n = 0; n < LANES; n++) v[n] = in_data[n*RATIO + k];
                    stream.push_back(v);
                end
            end
            exp_ur = 1'b0;
            if (stream.size() > 0) begin
                exp_q  = stream.pop_front();
                exp_ov = 1'b1;
            end else if (exp_ov) begin
                exp_q  = '0;
                exp_ov = 1'b0;
                exp_ur = 1'b1;
            end
        end
        #1;
        chk("Q", {6'd0, Q}, {6'd0, exp_q});
        chk("out_valid", {7'd0, out_valid}, {7'd0, exp_ov});
        chk("underrun", {7'd0, underrun}, {7'd0, exp_ur});
        if (out_valid) ov_cnt++;
        if (underrun) ur_cnt++;
    endtask

    task automatic send(input logic [7:0] w, output int waits);
        waits = 0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
            waits++;
        end
        chk("send_accepted", {7'd0, last_acc}, 8'd1);
    endtask

    task automatic idle_ticks(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    int w;
    logic [LANES-1:0] a5_bits[4];

    initial begin
        reset = 1'b1; set = 1'b0; ce = 1'b1; in_valid = 1'b0; in_data = '0;
        a5_bits[0] = 2'b01; a5_bits[1] = 2'b10; a5_bits[2] = 2'b01; a5_bits[3] = 2'b10;

        // 1: reset
        for (int i = 0; i < 3; i++) tick();
        chk("rst_Q", {6'd0, Q}, 8'h00);
        chk("rst_ov", {7'd0, out_valid}, 8'h00);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {7'd0, in_ready}, 8'h01);

        // 2: single word
        send(8'hA5, w);
        in_valid = 1'b0;
        chk("s2_bit0", {6'd0, Q}, {6'd0, a5_bits[0]});
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("s2_bit", {6'd0, Q}, {6'd0, a5_bits[k]});
        end
        tick();
        chk("s2_end_Q", {6'd0, Q}, 8'h00);
        chk("s2_end_ur", {7'd0, underrun}, 8'h01);
        tick();
        chk("s2_ur_drop", {7'd0, underrun}, 8'h00);
        idle_ticks(2);

        // 3: back-to-back words
        ov_cnt = 0; ur_cnt = 0;
        send(8'h12, w); send(8'h34, w); send(8'h56, w);
        idle_ticks(14);
        chk("s3_ov_cycles", ov_cnt[7:0], 8'd12);
        chk("s3_ur_pulses", ur_cnt[7:0], 8'd1);

        // 4: backpressure
        send(8'h12, w); send(8'h34, w);
        send(8'hFF, w);
        chk("s4_stall", w[7:0], 8'd3);
        idle_ticks(14);

        // 5: clock enable freeze after bit 1
        send(8'hA5, w);
        in_valid = 1'b0;
        tick();
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s5_frozen_Q", {6'd0, Q}, {6'd0, a5_bits[1]});
            chk("s5_frozen_ov", {7'd0, out_valid}, 8'h01);
        end
        ce = 1'b1;
        tick();
        chk("s5_bit2", {6'd0, Q}, {6'd0, a5_bits[2]});
        tick();
        chk("s5_bit3", {6'd0, Q}, {6'd0, a5_bits[3]});
        idle_ticks(3);

        // 6: reset then set mid-word with hold full
        for (int r = 0; r < 2; r++) begin
            send(8'hA5, w); send(8'h3C, w);
            in_valid = 1'b0;
            tick();
            if (r == 0) reset = 1'b1; else set = 1'b1;
            tick();
            reset = 1'b0; set = 1'b0;
            chk("s6_Q", {6'd0, Q}, (r == 0) ? 8'h00 : 8'h03);
            chk("s6_ov", {7'd0, out_valid}, 8'h00);
            chk("s6_ur", {7'd0, underrun}, 8'h00);
            ov_cnt = 0;
            idle_ticks(8);
            chk("s6_no_resume", ov_cnt[7:0], 8'd0);
        end

        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 99) < 70);
            in_data  = 8'($urandom);
            ce       = ($urandom_range(0, 99) < 90);
            reset    = ($urandom_range(0, 99) < 2);
            set      = ($urandom_range(0, 99) < 2);
            tick();
        end
        reset = 1'b0; set = 1'b0; ce = 1'b1;
        idle_ticks(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
